// File: rtl/ber_checker.sv
// Per-lane BER checker: sweeps a reference delay line to find link latency,
// then accumulates compared-bit and error counts while locked.
module ber_checker #(
  parameter int unsigned NB_DELAY   = 9,
  parameter int unsigned WIN_LEN    = 1024,
  parameter int unsigned LOCK_THR   = 10,
  parameter int unsigned UNLOCK_THR = 100,
  parameter int unsigned NB_CNT     = 32
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_rx_bit,
  input  logic                i_ref_bit,
  input  logic                i_clear,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_delay,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count
);

  localparam int unsigned DEPTH = 2 ** NB_DELAY;
  localparam int unsigned NB_WC = $clog2(WIN_LEN);
  localparam int unsigned NB_WE = $clog2(WIN_LEN + 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_SEARCH,
    S_LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [DEPTH-1:0]    line_q;
  logic [NB_DELAY-1:0] fill_q, fill_d;
  logic [NB_WC-1:0]    wcnt_q, wcnt_d;
  logic [NB_WE-1:0]    werr_q, werr_d;
  logic [NB_DELAY-1:0] delay_q, delay_d;
  logic [NB_CNT-1:0]   bits_q, bits_d;
  logic [NB_CNT-1:0]   errs_q, errs_d;
  logic                locked_q;

  logic             tap;
  logic             err;
  logic             win_end;
  logic             fill_end;
  logic             lock_ok;
  logic             unlock_hit;
  logic [NB_WE-1:0] win_tot;

  // Reference tap and window bookkeeping for the current strobe.
  always_comb begin
    if (delay_q == '0) tap = i_ref_bit;
    else               tap = line_q[delay_q - NB_DELAY'(1)];
    err        = i_rx_bit ^ tap;
    win_end    = (wcnt_q == NB_WC'(WIN_LEN - 1));
    fill_end   = (fill_q == '1);
    win_tot    = werr_q + NB_WE'(err);
    lock_ok    = (32'(win_tot) <= LOCK_THR);
    unlock_hit = (32'(win_tot) > UNLOCK_THR);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (i_reset) state_q <= S_FILL;
    else         state_q <= state_d;
  end

  // Next-state decision, taken only on a strobe.
  always_comb begin
    state_d = state_q;
    if (i_valid) begin
      unique case (state_q)
        S_FILL:   if (fill_end) state_d = S_SEARCH;
        S_SEARCH: if (win_end && lock_ok) state_d = S_LOCKED;
        S_LOCKED: if (win_end && unlock_hit) state_d = S_SEARCH;
        default:  state_d = S_FILL;
      endcase
    end
  end

  // Datapath next values: fill/window counters, delay step, accumulators.
  always_comb begin
    fill_d  = fill_q;
    wcnt_d  = wcnt_q;
    werr_d  = werr_q;
    delay_d = delay_q;
    bits_d  = bits_q;
    errs_d  = errs_q;
    if (i_valid) begin
      if (state_q == S_FILL) begin
        fill_d = fill_q + NB_DELAY'(1);
      end else begin
        wcnt_d = win_end ? '0 : wcnt_q + NB_WC'(1);
        werr_d = win_end ? '0 : win_tot;
        if (win_end &&
            ((state_q == S_SEARCH && !lock_ok) ||
             (state_q == S_LOCKED && unlock_hit)))
          delay_d = delay_q + NB_DELAY'(1);
        if (state_q == S_LOCKED) begin
          if (bits_q != '1) bits_d = bits_q + NB_CNT'(1);
          if (err && errs_q != '1) errs_d = errs_q + NB_CNT'(1);
        end
      end
    end
    if (i_clear) begin
      bits_d = '0;
      errs_d = '0;
    end
  end

  // Datapath registers and reference delay line.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      line_q   <= '0;
      fill_q   <= '0;
      wcnt_q   <= '0;
      werr_q   <= '0;
      delay_q  <= '0;
      bits_q   <= '0;
      errs_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      if (i_valid) line_q <= {line_q[DEPTH-2:0], i_ref_bit};
      fill_q   <= fill_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      delay_q  <= delay_d;
      bits_q   <= bits_d;
      errs_q   <= errs_d;
      locked_q <= (state_d == S_LOCKED);
    end
  end

  assign o_locked    = locked_q;
  assign o_delay     = delay_q;
  assign o_bit_count = bits_q;
  assign o_err_count = errs_q;

endmodule
